// File: rtl/cell_select_decoder_if.sv
// Move-entry bus between the move source and the cell select decoder.
// The request side is a plain strobe: no ready, every edge with sel_valid=1 is one request.
interface cell_select_decoder_if #(
   parameter int CELLS = 9,
   parameter int SEL_W = 4
);
   logic             sel_valid;
   logic [SEL_W-1:0] sel;
   logic             clear;
   logic [CELLS-1:0] en;
   logic             player;
   logic             en_player;
   logic [CELLS-1:0] occupied;
   logic [SEL_W-1:0] move_count;
   logic             move_ok;
   logic             move_err;
   logic             board_full;
   logic             state_dbg;

   modport master (
      output sel_valid, sel, clear,
      input  en, player, en_player, occupied, move_count,
      input  move_ok, move_err, board_full, state_dbg
   );

   modport slave (
      input  sel_valid, sel, clear,
      output en, player, en_player, occupied, move_count,
      output move_ok, move_err, board_full, state_dbg
   );
endinterface

// File: rtl/cell_select_decoder.sv
// Registered board cell decoder: validates a move against range and occupancy,
// pulses a one-hot cell enable, and tracks turn, move count and full board.
module cell_select_decoder #(
   parameter int CELLS = 9,
   parameter int SEL_W = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   cell_select_decoder_if.slave  bus
);

   typedef enum logic {
      PLAY = 1'b0,
      FULL = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] FULL_COUNT = SEL_W'(CELLS);
   localparam logic [SEL_W-1:0] LAST_COUNT = SEL_W'(CELLS - 1);

   state_t           state;
   logic [CELLS-1:0] en_q;
   logic             player_q;
   logic             en_player_q;
   logic [CELLS-1:0] occupied_q;
   logic [SEL_W-1:0] move_count_q;
   logic             move_ok_q;
   logic             move_err_q;
   logic             board_full_q;

   logic [CELLS-1:0] sel_onehot;
   logic             in_range;
   logic             legal;

   // An out-of-range index decodes to all zeros, so range and occupancy share one decode.
   always_comb begin
      sel_onehot = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            sel_onehot[i] = 1'b1;
         end
      end
   end

   assign in_range = |sel_onehot;
   assign legal    = in_range && ((occupied_q & sel_onehot) == '0);

   always_ff @(posedge clock) begin
      if (reset || bus.clear) begin
         state        <= PLAY;
         en_q         <= '0;
         player_q     <= 1'b0;
         en_player_q  <= 1'b0;
         occupied_q   <= '0;
         move_count_q <= '0;
         move_ok_q    <= 1'b0;
         move_err_q   <= 1'b0;
         board_full_q <= 1'b0;
      end else begin
         en_q       <= '0;
         move_ok_q  <= 1'b0;
         move_err_q <= 1'b0;
         if (bus.sel_valid) begin
            if (state == PLAY && legal) begin
               en_q        <= sel_onehot;
               en_player_q <= player_q;
               occupied_q  <= occupied_q | sel_onehot;
               player_q    <= ~player_q;
               move_ok_q   <= 1'b1;
               if (move_count_q != FULL_COUNT) begin
                  move_count_q <= move_count_q + 1'b1;
               end
               if (move_count_q == LAST_COUNT) begin
                  state        <= FULL;
                  board_full_q <= 1'b1;
               end
            end else begin
               move_err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.en         = en_q;
   assign bus.player     = player_q;
   assign bus.en_player  = en_player_q;
   assign bus.occupied   = occupied_q;
   assign bus.move_count = move_count_q;
   assign bus.move_ok    = move_ok_q;
   assign bus.move_err   = move_err_q;
   assign bus.board_full = board_full_q;
   assign bus.state_dbg  = state;

endmodule

// File: tb/tb_cell_select_decoder.sv
// Bench for cell_select_decoder: a 3x3 and a 4x4 instance driven in turn,
// checked against a board model built from the move rules.
module tb_cell_select_decoder;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   cell_select_decoder_if #(.CELLS(9),  .SEL_W(4)) b9 ();
   cell_select_decoder_if #(.CELLS(16), .SEL_W(5)) b16 ();

   cell_select_decoder #(.CELLS(9), .SEL_W(4)) dut9 (
      .clock (clock),
      .reset (reset),
      .bus   (b9)
   );

   cell_select_decoder #(.CELLS(16), .SEL_W(5)) dut16 (
      .clock (clock),
      .reset (reset),
      .bus   (b16)
   );

   int checks = 0;
   int errors = 0;
   int which  = 0;

   // board model
   int          m_cells = 9;
   bit          m_occ[16];
   int          m_count;
   bit          m_turn;
   bit          m_en_player;
   logic [15:0] m_en;
   bit          m_ok;
   bit          m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_occ[i] = 1'b0;
      m_count     = 0;
      m_turn      = 1'b0;
      m_en_player = 1'b0;
      m_en        = '0;
      m_ok        = 1'b0;
      m_err       = 1'b0;
   endtask

   task automatic model_step(input bit zap, input bit vld, input int s);
      m_en  = '0;
      m_ok  = 1'b0;
      m_err = 1'b0;
      if (zap) begin
         model_reset();
      end else if (vld) begin
         if (m_count < m_cells && s < m_cells && !m_occ[s]) begin
            m_en[s]     = 1'b1;
            m_en_player = m_turn;
            m_occ[s]    = 1'b1;
            m_turn      = ~m_turn;
            m_count     = m_count + 1;
            m_ok        = 1'b1;
         end else begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      logic [15:0] o_en, o_occ, e_occ;
      logic [31:0] o_cnt;
      logic        o_pl, o_epl, o_ok, o_err, o_full, o_st;
      bit          e_full;
      if (which == 0) begin
         o_en  = 16'(b9.en);
         o_occ = 16'(b9.occupied);
         o_cnt = 32'(b9.move_count);
         o_pl  = b9.player;     o_epl = b9.en_player;
         o_ok  = b9.move_ok;    o_err = b9.move_err;
         o_full = b9.board_full; o_st = b9.state_dbg;
      end else begin
         o_en  = b16.en;
         o_occ = b16.occupied;
         o_cnt = 32'(b16.move_count);
         o_pl  = b16.player;     o_epl = b16.en_player;
         o_ok  = b16.move_ok;    o_err = b16.move_err;
         o_full = b16.board_full; o_st = b16.state_dbg;
      end
      e_occ = '0;
      for (int i = 0; i < 16; i++) e_occ[i] = m_occ[i];
      e_full = (m_count == m_cells);
      check("en",         32'(o_en),   32'(m_en));
      check("occupied",   32'(o_occ),  32'(e_occ));
      check("move_count", o_cnt,       32'(m_count));
      check("player",     32'(o_pl),   32'(m_turn));
      check("en_player",  32'(o_epl),  32'(m_en_player));
      check("move_ok",    32'(o_ok),   32'(m_ok));
      check("move_err",   32'(o_err),  32'(m_err));
      check("board_full", 32'(o_full), 32'(e_full));
      check("state",      32'(o_st),   32'(e_full));
   endtask

   task automatic step(input bit rst, input bit clr, input bit vld, input int s);
      @(negedge clock);
      reset = rst;
      b9.clear = 1'b0;  b9.sel_valid = 1'b0;  b9.sel = '0;
      b16.clear = 1'b0; b16.sel_valid = 1'b0; b16.sel = '0;
      if (which == 0) begin
         b9.clear = clr; b9.sel_valid = vld; b9.sel = 4'(s);
      end else begin
         b16.clear = clr; b16.sel_valid = vld; b16.sel = 5'(s);
      end
      model_step(rst || clr, vld, s);
      @(posedge clock);
      #1;
      compare_all();
   endtask

   task automatic random_run(input int n);
      for (int k = 0; k < n; k++) begin
         step(1'b0, ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, m_cells + 2)));
      end
   endtask

   initial begin
      b9.clear = 1'b0;  b9.sel_valid = 1'b0;  b9.sel = '0;
      b16.clear = 1'b0; b16.sel_valid = 1'b0; b16.sel = '0;
      model_reset();

      // 3x3 board
      which   = 0;
      m_cells = 9;
      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 4);
      step(1'b0, 1'b0, 1'b1, 4);
      step(1'b0, 1'b0, 1'b1, 9);
      step(1'b0, 1'b0, 1'b1, 15);
      foreach (m_occ[i]) if (i < 9 && i != 4) step(1'b0, 1'b0, 1'b1, i);
      step(1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 1'b1, 2);
      // accepted move followed at once by reset: the pulse shows, then state is zeroed
      step(1'b0, 1'b0, 1'b1, 3);
      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 7);
      step(1'b0, 1'b1, 1'b0, 0);
      random_run(300);

      // 4x4 board
      which   = 1;
      m_cells = 16;
      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 15);
      step(1'b0, 1'b0, 1'b1, 16);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, i);
      step(1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 1'b1, 31);
      step(1'b0, 1'b1, 1'b0, 0);
      random_run(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cell_select_decoder.md
Name: cell_select_decoder

Overview:
- Parametrised, registered successor to the tic-tac-toe board decoder.
- Accepts a move request (cell index), validates it against range and an internal occupancy map, then emits a one-cycle one-hot enable to the addressed cell register.
- Tracks whose turn it is and how many moves have been played, and flags illegal moves and a full board.
- Sits between the input/move-entry logic and the per-cell storage registers.

Parameters:
- CELLS, 9, number of board cells; one-hot enable width (9 = 3x3, 16 = 4x4).
- SEL_W, 4, width of cell index and move counter; must satisfy 2^SEL_W > CELLS.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high; clears all state.
- sel_valid  input  1  move request strobe, sampled each rising edge.
- sel  input  SEL_W  requested cell index, 0..CELLS-1.
- clear  input  1  synchronous new-game request.
- en  output  CELLS  one-hot cell write enable, one-cycle pulse; en[i] targets cell i (en1 is en[0]).
- player  output  1  player to move: 0 = X, 1 = O.
- en_player  output  1  player who owns the move in the current en pulse.
- occupied  output  CELLS  occupancy map; bit i set once cell i is written.
- move_count  output  SEL_W  number of accepted moves since reset or clear.
- move_ok  output  1  one-cycle pulse, request accepted.
- move_err  output  1  one-cycle pulse, request rejected.
- board_full  output  1  high while in the FULL state.

Behaviour:
- Reset: synchronous and active-high; takes effect on the rising edge while high.
- Reset values: en=0, player=0, en_player=0, occupied=0, move_count=0, move_ok=0, move_err=0, board_full=0, state=PLAY.
- All outputs are registered. A request is sampled at edge N; the result is visible after edge N and lasts one cycle for the pulses en, move_ok and move_err.
- State machine:
  - PLAY: requests are evaluated.
  - FULL: entered on the edge that accepts the move making move_count equal CELLS. board_full=1. Every request in FULL gives move_err.
  - Both states go to PLAY on clear or reset.
- Request evaluation in PLAY, when sel_valid=1:
  - Legal if sel < CELLS and occupied[sel] = 0.
  - Legal request, on the next edge:
    - en[sel]=1;
    - en_player = current player;
    - occupied[sel] set;
    - player toggles;
    - move_count +1;
    - move_ok=1.
  - Illegal request (out of range, occupied, or state FULL): en=0, move_err=1, no other state change.
  - sel_valid=0: en, move_ok and move_err are 0.
- Priority: reset > clear > sel_valid. Clear behaves like reset except it is the game-level control. A request in the same cycle as clear is dropped, with no move_err.
- Back-to-back requests on consecutive cycles are each evaluated against occupancy already updated by the previous accepted move. The same cell twice in a row gives move_ok, then move_err.
- en is always zero or one-hot. move_ok and move_err are never high together.
- move_count saturates at CELLS; it never wraps.
- Reset or clear in the cycle after an accepted request does not suppress the en pulse already registered. The pulse completes; the state is zeroed on the following edge.

Test Plan:
- Reset then idle: hold reset 2 cycles, sel_valid=0 for 5 cycles -> all outputs 0, state PLAY.
- Legal first move: sel=4, sel_valid=1 for one cycle -> next cycle:
  - en=9'b000010000, en_player=0, move_ok=1;
  - occupied=9'h010, player=1, move_count=1.
- Occupied and out-of-range: repeat sel=4, then sel=9, sel=15 -> three move_err pulses, en=0, occupied and move_count unchanged, player stays 1.
- Fill board: legal moves 0,1,2,3,5,6,7,8 back-to-back -> en walks the one-hot positions, player alternates. After the 9th accepted move: move_count=9, occupied=9'h1FF, board_full=1. A further request sel=0 -> move_err.
- Clear priority: clear=1 with sel_valid=1, sel=2 in the same cycle -> no en, no move_ok, no move_err; occupied=0, player=0, move_count=0, board_full=0.
- Parametrised: CELLS=16, SEL_W=5 -> sel=15 gives en=16'h8000; sel=16 gives move_err; 16 moves set board_full.
